// File: rtl/cfg_stream_sequencer_pkg.sv
// Shared layer geometry, word width and sequencer types.
// No logic of its own; combinational helpers only.
// Not applicable (no handshake).
package cfg_stream_sequencer_pkg;

    // Default network geometry, shared with the neuron array
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_LAYERS = 4;
    localparam int DEF_L1_NEURONS = 30;
    localparam int DEF_L1_WEIGHTS = 784;
    localparam int DEF_L2_NEURONS = 30;
    localparam int DEF_L2_WEIGHTS = 30;
    localparam int DEF_L3_NEURONS = 10;
    localparam int DEF_L3_WEIGHTS = 30;
    localparam int DEF_L4_NEURONS = 10;
    localparam int DEF_L4_WEIGHTS = 10;
    // Layers 5..7 only matter when numLayers is raised above 4
    localparam int DEF_LX_NEURONS = 1;
    localparam int DEF_LX_WEIGHTS = 1;

    localparam int NEURON_CNT_W = 6;   // holds a neuron count up to 32
    localparam int WEIGHT_CNT_W = 10;  // holds a weight count up to 1023

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_LOAD_B = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [NEURON_CNT_W-1:0] neurons;
        logic [WEIGHT_CNT_W-1:0] weights;
    } layer_dims_t;

    function automatic layer_dims_t make_dims(input int n, input int w);
        layer_dims_t d;
        d.neurons = NEURON_CNT_W'(n);
        d.weights = WEIGHT_CNT_W'(w);
        return d;
    endfunction

endpackage

// File: rtl/cfg_stream_sequencer_layer_dims_lut.sv
// Layer number -> (neuron count, weights per neuron) lookup.
// Purely combinational, zero latency.
// No flow control; unused layer numbers return 1x1.
module layer_dims_lut
    import cfg_stream_sequencer_pkg::*;
#(
    parameter int L1_NEURONS = DEF_L1_NEURONS,
    parameter int L1_WEIGHTS = DEF_L1_WEIGHTS,
    parameter int L2_NEURONS = DEF_L2_NEURONS,
    parameter int L2_WEIGHTS = DEF_L2_WEIGHTS,
    parameter int L3_NEURONS = DEF_L3_NEURONS,
    parameter int L3_WEIGHTS = DEF_L3_WEIGHTS,
    parameter int L4_NEURONS = DEF_L4_NEURONS,
    parameter int L4_WEIGHTS = DEF_L4_WEIGHTS,
    parameter int L5_NEURONS = DEF_LX_NEURONS,
    parameter int L5_WEIGHTS = DEF_LX_WEIGHTS,
    parameter int L6_NEURONS = DEF_LX_NEURONS,
    parameter int L6_WEIGHTS = DEF_LX_WEIGHTS,
    parameter int L7_NEURONS = DEF_LX_NEURONS,
    parameter int L7_WEIGHTS = DEF_LX_WEIGHTS
) (
    input  logic [2:0]  layer,
    output layer_dims_t dims
);

    // Select the geometry of the addressed layer
    always_comb begin
        dims = make_dims(1, 1);
        case (layer)
            3'd1:    dims = make_dims(L1_NEURONS, L1_WEIGHTS);
            3'd2:    dims = make_dims(L2_NEURONS, L2_WEIGHTS);
            3'd3:    dims = make_dims(L3_NEURONS, L3_WEIGHTS);
            3'd4:    dims = make_dims(L4_NEURONS, L4_WEIGHTS);
            3'd5:    dims = make_dims(L5_NEURONS, L5_WEIGHTS);
            3'd6:    dims = make_dims(L6_NEURONS, L6_WEIGHTS);
            3'd7:    dims = make_dims(L7_NEURONS, L7_WEIGHTS);
            default: dims = make_dims(1, 1);
        endcase
    end

endmodule

// File: rtl/cfg_stream_sequencer.sv
// Turns a flat weight/bias word stream into per-neuron config write strobes.
// Latency 1 cycle from input handshake to registered output word.
// Input stalls freely via cfg_in_valid; no downstream backpressure exists.
module cfg_stream_sequencer
    import cfg_stream_sequencer_pkg::*;
#(
    parameter int dataWidth  = DEF_DATA_WIDTH,
    parameter int numLayers  = DEF_NUM_LAYERS,
    parameter int L1_NEURONS = DEF_L1_NEURONS,
    parameter int L1_WEIGHTS = DEF_L1_WEIGHTS,
    parameter int L2_NEURONS = DEF_L2_NEURONS,
    parameter int L2_WEIGHTS = DEF_L2_WEIGHTS,
    parameter int L3_NEURONS = DEF_L3_NEURONS,
    parameter int L3_WEIGHTS = DEF_L3_WEIGHTS,
    parameter int L4_NEURONS = DEF_L4_NEURONS,
    parameter int L4_WEIGHTS = DEF_L4_WEIGHTS
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_aresetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [dataWidth-1:0] cfg_in_data,
    input  logic                 cfg_in_valid,
    output logic                 cfg_in_ready,
    output logic [2:0]           cfg_layer,
    output logic [4:0]           cfg_neuron,
    output logic [dataWidth-1:0] cfg_data,
    output logic                 cfg_weight_valid,
    output logic                 cfg_bias_valid,
    output logic                 busy,
    output logic                 done
);

    seq_state_t              state_q, state_d;
    logic [2:0]              layer_q, layer_d;
    logic [4:0]              neuron_q, neuron_d;
    logic [WEIGHT_CNT_W-1:0] widx_q, widx_d;

    logic [2:0]              out_layer_q, out_layer_d;
    logic [4:0]              out_neuron_q, out_neuron_d;
    logic [dataWidth-1:0]    out_data_q, out_data_d;
    logic                    wvld_q, wvld_d;
    logic                    bvld_q, bvld_d;
    logic                    done_q, done_d;

    layer_dims_t dims;
    logic        hs;
    logic        last_w;
    logic        last_n;
    logic        last_l;

    layer_dims_lut #(
        .L1_NEURONS (L1_NEURONS),
        .L1_WEIGHTS (L1_WEIGHTS),
        .L2_NEURONS (L2_NEURONS),
        .L2_WEIGHTS (L2_WEIGHTS),
        .L3_NEURONS (L3_NEURONS),
        .L3_WEIGHTS (L3_WEIGHTS),
        .L4_NEURONS (L4_NEURONS),
        .L4_WEIGHTS (L4_WEIGHTS)
    ) u_dims (
        .layer (layer_q),
        .dims  (dims)
    );

    // Ready masks abort so an aborting cycle never consumes a word
    assign cfg_in_ready = (state_q != ST_IDLE) && !abort;
    assign busy         = (state_q != ST_IDLE);
    assign hs           = cfg_in_valid && cfg_in_ready;

    assign last_w = (widx_q == dims.weights - WEIGHT_CNT_W'(1));
    assign last_n = ({1'b0, neuron_q} == dims.neurons - NEURON_CNT_W'(1));
    assign last_l = (layer_q >= 3'(numLayers));

    assign cfg_layer        = out_layer_q;
    assign cfg_neuron       = out_neuron_q;
    assign cfg_data         = out_data_q;
    assign cfg_weight_valid = wvld_q;
    assign cfg_bias_valid   = bvld_q;
    assign done             = done_q;

    // Next state, counter advance and output word capture
    always_comb begin
        state_d      = state_q;
        layer_d      = layer_q;
        neuron_d     = neuron_q;
        widx_d       = widx_q;
        out_layer_d  = out_layer_q;
        out_neuron_d = out_neuron_q;
        out_data_d   = out_data_q;
        wvld_d       = 1'b0;
        bvld_d       = 1'b0;
        done_d       = 1'b0;

        // Tag the accepted word with the position it was accepted at
        if (hs) begin
            out_layer_d  = layer_q;
            out_neuron_d = neuron_q;
            out_data_d   = cfg_in_data;
        end

        if (abort) begin
            state_d  = ST_IDLE;
            layer_d  = '0;
            neuron_d = '0;
            widx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d  = ST_LOAD_W;
                        layer_d  = 3'd1;
                        neuron_d = '0;
                        widx_d   = '0;
                    end
                end
                ST_LOAD_W: begin
                    if (hs) begin
                        wvld_d = 1'b1;
                        if (last_w) begin
                            state_d = ST_LOAD_B;
                        end else begin
                            widx_d = widx_q + WEIGHT_CNT_W'(1);
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (hs) begin
                        bvld_d = 1'b1;
                        widx_d = '0;
                        if (!last_n) begin
                            neuron_d = neuron_q + 5'd1;
                            state_d  = ST_LOAD_W;
                        end else if (!last_l) begin
                            layer_d  = layer_q + 3'd1;
                            neuron_d = '0;
                            state_d  = ST_LOAD_W;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, counters and output registers
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q      <= ST_IDLE;
            layer_q      <= '0;
            neuron_q     <= '0;
            widx_q       <= '0;
            out_layer_q  <= '0;
            out_neuron_q <= '0;
            out_data_q   <= '0;
            wvld_q       <= 1'b0;
            bvld_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            neuron_q     <= neuron_d;
            widx_q       <= widx_d;
            out_layer_q  <= out_layer_d;
            out_neuron_q <= out_neuron_d;
            out_data_q   <= out_data_d;
            wvld_q       <= wvld_d;
            bvld_q       <= bvld_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_cfg_stream_sequencer.sv
// Randomized bench for cfg_stream_sequencer against a word-index reference model.
// Drives and samples on the falling edge; one default and one reduced instance.
// Ready is predicted by the model and compared every cycle.
module tb_cfg_stream_sequencer;

    logic        clk;
    logic        rst_n;
    logic        sel;            // 0: default instance, 1: reduced instance
    logic        start_i, abort_i, valid_i;
    logic [15:0] data_i;

    logic        rdy_a, wv_a, bv_a, busy_a, done_a;
    logic [2:0]  lay_a;
    logic [4:0]  neu_a;
    logic [15:0] dat_a;
    logic        rdy_b, wv_b, bv_b, busy_b, done_b;
    logic [2:0]  lay_b;
    logic [4:0]  neu_b;
    logic [15:0] dat_b;

    logic        o_rdy, o_wv, o_bv, o_busy, o_done;
    logic [2:0]  o_lay;
    logic [4:0]  o_neu;
    logic [15:0] o_dat;

    cfg_stream_sequencer dut (
        .s_axi_aclk       (clk),
        .s_axi_aresetn    (rst_n),
        .start            (start_i & ~sel),
        .abort            (abort_i & ~sel),
        .cfg_in_data      (data_i),
        .cfg_in_valid     (valid_i & ~sel),
        .cfg_in_ready     (rdy_a),
        .cfg_layer        (lay_a),
        .cfg_neuron       (neu_a),
        .cfg_data         (dat_a),
        .cfg_weight_valid (wv_a),
        .cfg_bias_valid   (bv_a),
        .busy             (busy_a),
        .done             (done_a)
    );

    cfg_stream_sequencer #(
        .numLayers  (2),
        .L1_NEURONS (2), .L1_WEIGHTS (3),
        .L2_NEURONS (2), .L2_WEIGHTS (3)
    ) dut_s (
        .s_axi_aclk       (clk),
        .s_axi_aresetn    (rst_n),
        .start            (start_i & sel),
        .abort            (abort_i & sel),
        .cfg_in_data      (data_i),
        .cfg_in_valid     (valid_i & sel),
        .cfg_in_ready     (rdy_b),
        .cfg_layer        (lay_b),
        .cfg_neuron       (neu_b),
        .cfg_data         (dat_b),
        .cfg_weight_valid (wv_b),
        .cfg_bias_valid   (bv_b),
        .busy             (busy_b),
        .done             (done_b)
    );

    always_comb begin
        o_rdy  = sel ? rdy_b  : rdy_a;
        o_wv   = sel ? wv_b   : wv_a;
        o_bv   = sel ? bv_b   : bv_a;
        o_busy = sel ? busy_b : busy_a;
        o_done = sel ? done_b : done_a;
        o_lay  = sel ? lay_b  : lay_a;
        o_neu  = sel ? neu_b  : neu_a;
        o_dat  = sel ? dat_b  : dat_a;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: the stream is a list of words indexed from 0
    int m_nl;
    int m_n[1:7];
    int m_w[1:7];
    int m_total;
    bit m_busy;
    int m_k;
    int act_valids, act_dones;

    // Landmark words: {wv, bv, done, layer[2:0], neuron[4:0]}
    int          spot_idx_a[5] = '{0, 784, 785, 23550, 24899};
    logic [10:0] spot_exp_a[5] = '{{3'b100, 3'd1, 5'd0}, {3'b010, 3'd1, 5'd0},
                                   {3'b100, 3'd1, 5'd1}, {3'b100, 3'd2, 5'd0},
                                   {3'b011, 3'd4, 5'd9}};
    int          spot_idx_b[5] = '{3, 4, 7, 8, 15};
    logic [10:0] spot_exp_b[5] = '{{3'b010, 3'd1, 5'd0}, {3'b100, 3'd1, 5'd1},
                                   {3'b010, 3'd1, 5'd1}, {3'b100, 3'd2, 5'd0},
                                   {3'b011, 3'd2, 5'd1}};

    task automatic set_cfg(input bit s);
        sel = s;
        for (int l = 1; l <= 7; l++) begin
            m_n[l] = 1;
            m_w[l] = 1;
        end
        if (!s) begin
            m_nl = 4;
            m_n[1] = 30; m_w[1] = 784;
            m_n[2] = 30; m_w[2] = 30;
            m_n[3] = 10; m_w[3] = 30;
            m_n[4] = 10; m_w[4] = 10;
        end else begin
            m_nl = 2;
            m_n[1] = 2; m_w[1] = 3;
            m_n[2] = 2; m_w[2] = 3;
        end
        m_total = 0;
        for (int l = 1; l <= m_nl; l++) m_total += m_n[l] * (m_w[l] + 1);
        m_busy = 1'b0;
        m_k    = 0;
    endtask

    // Word index -> (layer, neuron, is-bias) by walking layer sizes
    function automatic void locate(input int k, output int lay, output int neu, output bit isb);
        int r = k;
        lay = 0; neu = 0; isb = 1'b0;
        for (int l = 1; l <= m_nl; l++) begin
            int per = m_w[l] + 1;
            if (r < m_n[l] * per) begin
                lay = l;
                neu = r / per;
                isb = ((r % per) == m_w[l]);
                return;
            end
            r -= m_n[l] * per;
        end
    endfunction

    // One clock: drive at falling edge, predict, compare at next falling edge
    task automatic cycle(input bit v, input bit s, input bit a);
        logic [15:0] d;
        bit          hs, isb;
        bit          e_wv, e_bv, e_done;
        int          lay, neu, idx;
        logic [27:0] act, exp, mask;
        d = 16'($urandom);
        valid_i = v; start_i = s; abort_i = a; data_i = d;
        #1;
        check_eq("ready", 64'(o_rdy), 64'(m_busy & ~a));
        hs = v & m_busy & ~a;
        e_wv = 1'b0; e_bv = 1'b0; e_done = 1'b0; lay = 0; neu = 0; idx = -1;
        if (a) begin
            m_busy = 1'b0;
            m_k    = 0;
        end else if (!m_busy) begin
            if (s) begin
                m_busy = 1'b1;
                m_k    = 0;
            end
        end else if (hs) begin
            locate(m_k, lay, neu, isb);
            e_bv = isb;
            e_wv = !isb;
            idx  = m_k;
            m_k++;
            if (m_k == m_total) begin
                m_busy = 1'b0;
                e_done = 1'b1;
            end
        end
        @(negedge clk);
        act_valids += int'(o_wv | o_bv);
        act_dones  += int'(o_done);
        mask = (e_wv | e_bv) ? 28'hFFF_FFFF : 28'hF00_0000;
        act  = {o_busy, o_done, o_wv, o_bv, o_lay, o_neu, o_dat} & mask;
        exp  = {m_busy, e_done, e_wv, e_bv, 3'(lay), 5'(neu), d} & mask;
        check_eq("word_out", 64'(act), 64'(exp));
        if (idx >= 0) begin
            for (int i = 0; i < 5; i++) begin
                if (!sel && idx == spot_idx_a[i])
                    check_eq($sformatf("landmark_a%0d", idx), 64'({o_wv, o_bv, o_done, o_lay, o_neu}), 64'(spot_exp_a[i]));
                if (sel && idx == spot_idx_b[i])
                    check_eq($sformatf("landmark_b%0d", idx), 64'({o_wv, o_bv, o_done, o_lay, o_neu}), 64'(spot_exp_b[i]));
            end
        end
    endtask

    // Full load from IDLE; mode 0 random density, 1 toggling 1-0-1
    task automatic run_load(input int density, input int start_pct, input bit toggle, input int limit);
        int c = 0;
        bit v;
        act_valids = 0;
        act_dones  = 0;
        cycle(1'b0, 1'b1, 1'b0);
        while (m_busy && c < limit) begin
            v = toggle ? (c % 2 == 0) : ($urandom_range(99) < density);
            cycle(v, $urandom_range(99) < start_pct, 1'b0);
            c++;
        end
        check_eq("load_finished", 64'(m_busy), 64'(0));
        check_eq("valid_count", 64'(act_valids), 64'(m_total));
        check_eq("done_count", 64'(act_dones), 64'(1));
    endtask

    // Start, consume `words` words continuously, then abort with valid high
    task automatic run_abort(input int words);
        act_dones = 0;
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < words && m_busy; i++) cycle(1'b1, 1'b0, 1'b0);
        check_eq("pre_abort_pos", 64'(m_k), 64'(words));
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        check_eq("abort_no_done", 64'(act_dones), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; valid_i = 1'b0; data_i = '0;
        set_cfg(1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_a", 64'({rdy_a, busy_a, done_a, wv_a, bv_a, lay_a, neu_a, dat_a}), 64'(0));
        check_eq("reset_b", 64'({rdy_b, busy_b, done_b, wv_b, bv_b, lay_b, neu_b, dat_b}), 64'(0));

        // Valid while idle, then start+abort together from idle
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        check_eq("idle_after_start_abort", 64'(o_busy), 64'(0));

        // Default geometry: continuous, gapped with stray starts, abort at L2 N5 W12
        run_load(100, 0, 1'b0, 30000);
        run_load(85, 2, 1'b0, 40000);
        run_abort(23550 + 5 * 31 + 12);
        run_abort(3);

        // Reduced geometry
        set_cfg(1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        run_load(0, 0, 1'b1, 200);
        for (int r = 0; r < 4; r++) run_load(60, 20, 1'b0, 400);
        run_abort(6);
        run_load(100, 0, 1'b0, 100);

        // Asynchronous reset mid-load clears outputs without a clock edge
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset", 64'({rdy_b, busy_b, done_b, wv_b, bv_b, lay_b, neu_b, dat_b}), 64'(0));
        m_busy = 1'b0;
        m_k    = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        run_load(100, 0, 1'b0, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
